// File: rtl/update_sched_pkg.sv
// Shared types and constants for the anchor-update scheduler.
package update_sched_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_DEL = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    WAIT
  } state_e;

  localparam int unsigned POS_W    = 18;
  localparam int unsigned FEAT_LEN = 9;

  typedef struct packed {
    op_e              op;
    logic [POS_W-1:0] pos;
  } cmd_t;

  // Beat counter must hold the value n (one past the last word index).
  function automatic int unsigned beat_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  localparam int unsigned BEAT_W = beat_width(FEAT_LEN);

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with registered occupancy count.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage array; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/update_scheduler.sv
// Front-end scheduler for the octree anchor updater: queues add/delete
// commands and feature words, issues one command at a time, streams the
// feature words cycle-exactly and waits for the matching done.
// Optional macro UPD_SCHED_TIMEOUT_EN adds a WAIT watchdog and err_timeout.
module update_scheduler
  import update_sched_pkg::*;
#(
  parameter int unsigned DATA_BUS_WIDTH    = 64,
  parameter int unsigned ENCODE_ADDR_WIDTH = 18,
  parameter int unsigned FEATURE_LENTH     = 9,
  parameter int unsigned CMD_DEPTH         = 4,
  parameter int unsigned FEAT_DEPTH        = 32
`ifdef UPD_SCHED_TIMEOUT_EN
  ,parameter int unsigned TIMEOUT_CYCLES   = 1024
`endif
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_op,
  input  logic [ENCODE_ADDR_WIDTH-1:0]  cmd_pos,
  input  logic                          feat_valid,
  output logic                          feat_ready,
  input  logic [DATA_BUS_WIDTH-1:0]     feat_data,
  output logic                          add_anchor,
  output logic                          del_anchor,
  output logic [ENCODE_ADDR_WIDTH-1:0]  pos_encode,
  output logic [DATA_BUS_WIDTH-1:0]     feature_in,
  input  logic                          add_done,
  input  logic                          del_done,
  output logic                          busy,
  output logic                          cmp_valid,
  output logic                          cmp_op,
  output logic [$clog2(CMD_DEPTH):0]    cmd_level
`ifdef UPD_SCHED_TIMEOUT_EN
  ,output logic                         err_timeout
`endif
);

  localparam int unsigned BW  = beat_width(FEATURE_LENTH);
  localparam int unsigned FCW = $clog2(FEAT_DEPTH) + 1;
  localparam int unsigned CW  = ENCODE_ADDR_WIDTH + 1;

  state_e                         state_q, state_d;
  logic [BW-1:0]                  beat_q;
  op_e                            op_q;
  logic [ENCODE_ADDR_WIDTH-1:0]   pos_q;
  logic                           done_seen_q;
  logic                           add_q, del_q;
  logic [DATA_BUS_WIDTH-1:0]      feat_q;

  logic                           cmd_pop, cmd_full, cmd_empty;
  logic [CW-1:0]                  cmd_head;
  logic                           feat_pop, feat_full, feat_empty;
  logic [DATA_BUS_WIDTH-1:0]      feat_head;
  logic [FCW-1:0]                 feat_count;

  op_e                            head_op;
  logic [ENCODE_ADDR_WIDTH-1:0]   head_pos;
  logic                           issue_add, issue_del;
  logic                           done_match, finish, timeout;

  sync_fifo #(.WIDTH(CW), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd_valid && cmd_ready),
    .din   ({cmd_op, cmd_pos}),
    .pop   (cmd_pop),
    .dout  (cmd_head),
    .full  (cmd_full),
    .empty (cmd_empty),
    .count (cmd_level)
  );

  sync_fifo #(.WIDTH(DATA_BUS_WIDTH), .DEPTH(FEAT_DEPTH)) u_feat_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (feat_valid && feat_ready),
    .din   (feat_data),
    .pop   (feat_pop),
    .dout  (feat_head),
    .full  (feat_full),
    .empty (feat_empty),
    .count (feat_count)
  );

  assign cmd_ready  = !cmd_full;
  assign feat_ready = !feat_full;
  assign head_op    = op_e'(cmd_head[ENCODE_ADDR_WIDTH]);
  assign head_pos   = cmd_head[ENCODE_ADDR_WIDTH-1:0];
  assign done_match = (op_q == OP_ADD) ? add_done : del_done;
  assign finish     = (state_q == WAIT) && (done_seen_q || done_match);

`ifdef UPD_SCHED_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TW-1:0] wait_cnt_q;

  assign timeout     = (state_q == WAIT) && !finish &&
                       (wait_cnt_q == TW'(TIMEOUT_CYCLES - 1));
  assign err_timeout = timeout;

  // Watchdog counts WAIT cycles; cleared whenever the FSM is elsewhere.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  wait_cnt_q <= '0;
    else if (state_q == WAIT) wait_cnt_q <= wait_cnt_q + 1'b1;
    else                      wait_cnt_q <= '0;
  end
`else
  assign timeout = 1'b0;
`endif

  assign add_anchor = add_q;
  assign del_anchor = del_q;
  assign pos_encode = pos_q;
  assign feature_in = feat_q;
  assign busy       = (state_q != IDLE);
  assign cmp_valid  = finish || timeout;
  assign cmp_op     = cmp_valid && (op_q == OP_DEL);

  // Next-state and FIFO pop decisions.
  always_comb begin
    state_d   = state_q;
    cmd_pop   = 1'b0;
    feat_pop  = 1'b0;
    issue_add = 1'b0;
    issue_del = 1'b0;
    case (state_q)
      IDLE: begin
        if (!cmd_empty) begin
          if (head_op == OP_DEL) begin
            cmd_pop   = 1'b1;
            issue_del = 1'b1;
            state_d   = WAIT;
          end else if (feat_count >= FCW'(FEATURE_LENTH)) begin
            cmd_pop   = 1'b1;
            feat_pop  = 1'b1;
            issue_add = 1'b1;
            state_d   = STREAM;
          end
        end
      end
      STREAM: begin
        if (beat_q < BW'(FEATURE_LENTH)) feat_pop = !feat_empty;
        else                             state_d  = WAIT;
      end
      WAIT: begin
        if (finish || timeout) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs: the pulse, pos and word 0 appear together on the
  // cycle after the IDLE decision; beat_q counts words already presented.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      op_q        <= OP_ADD;
      pos_q       <= '0;
      done_seen_q <= 1'b0;
      add_q       <= 1'b0;
      del_q       <= 1'b0;
      feat_q      <= '0;
    end else begin
      state_q <= state_d;
      add_q   <= issue_add;
      del_q   <= issue_del;
      if (issue_add || issue_del) begin
        op_q        <= head_op;
        pos_q       <= head_pos;
        done_seen_q <= 1'b0;
      end else if (state_q == STREAM && done_match) begin
        done_seen_q <= 1'b1;
      end
      if (issue_add) begin
        feat_q <= feat_head;
        beat_q <= BW'(1);
      end else if (state_q == STREAM && beat_q < BW'(FEATURE_LENTH)) begin
        feat_q <= feat_head;
        beat_q <= beat_q + 1'b1;
      end else begin
        feat_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_update_scheduler.sv
// Directed self-checking bench for update_scheduler with a scoreboard of
// expected issues, feature words and completions.
module tb_update_scheduler;
  import update_sched_pkg::*;

  localparam int unsigned DW = 64;
  localparam int unsigned AW = 18;
  localparam int unsigned FL = 9;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_op;
  logic [AW-1:0] cmd_pos;
  logic          feat_valid, feat_ready;
  logic [DW-1:0] feat_data;
  logic          add_anchor, del_anchor;
  logic [AW-1:0] pos_encode;
  logic [DW-1:0] feature_in;
  logic          add_done, del_done, busy, cmp_valid, cmp_op;
  logic [2:0]    cmd_level;
`ifdef UPD_SCHED_TIMEOUT_EN
  logic          err_timeout;
`endif

  always #5 clk = ~clk;

  update_scheduler #(
    .DATA_BUS_WIDTH   (DW),
    .ENCODE_ADDR_WIDTH(AW),
    .FEATURE_LENTH    (FL),
    .CMD_DEPTH        (4),
    .FEAT_DEPTH       (32)
`ifdef UPD_SCHED_TIMEOUT_EN
    ,.TIMEOUT_CYCLES  (16)
`endif
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_pos(cmd_pos),
    .feat_valid(feat_valid), .feat_ready(feat_ready), .feat_data(feat_data),
    .add_anchor(add_anchor), .del_anchor(del_anchor), .pos_encode(pos_encode),
    .feature_in(feature_in), .add_done(add_done), .del_done(del_done),
    .busy(busy), .cmp_valid(cmp_valid), .cmp_op(cmp_op), .cmd_level(cmd_level)
`ifdef UPD_SCHED_TIMEOUT_EN
    ,.err_timeout(err_timeout)
`endif
  );

  int unsigned   n_checks = 0;
  int unsigned   n_err    = 0;
  cmd_t          exp_cmd[$];
  logic [DW-1:0] exp_feat[$];
  op_e           exp_cmp[$];
  int            beats = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input op_e op, input logic [AW-1:0] pos);
    logic acc;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_pos   = pos;
    acc       = cmd_ready;
    tick();
    cmd_valid = 1'b0;
    if (acc) exp_cmd.push_back('{op: op, pos: pos});
  endtask

  task automatic push_feat(input logic [DW-1:0] d);
    logic acc;
    feat_valid = 1'b1;
    feat_data  = d;
    acc        = feat_ready;
    tick();
    feat_valid = 1'b0;
    if (acc) exp_feat.push_back(d);
  endtask

  task automatic wait_issue(input string tag);
    int n = 0;
    while (!(add_anchor || del_anchor) && n < 30) begin
      tick();
      n++;
    end
    check(tag, 64'(add_anchor || del_anchor), 64'd1);
  endtask

  task automatic flush_model();
    exp_cmd.delete();
    exp_feat.delete();
    exp_cmp.delete();
  endtask

  // Scoreboard monitor sampled on the falling edge.
  always @(negedge clk) begin : mon
    cmd_t c;
    op_e  o;
    if (rst) begin
      beats = 0;
    end else begin
      if (add_anchor || del_anchor) begin
        check("issue_one_hot", 64'(add_anchor && del_anchor), 64'd0);
        check("issue_expected", 64'(exp_cmd.size() != 0), 64'd1);
        if (exp_cmd.size() != 0) begin
          c = exp_cmd.pop_front();
          check("issue_op", 64'(del_anchor), 64'(c.op == OP_DEL));
          check("issue_pos", 64'(pos_encode), 64'(c.pos));
          exp_cmp.push_back(c.op);
        end
        if (add_anchor) beats = FL;
      end
      if (beats > 0) begin
        check("feat_expected", 64'(exp_feat.size() != 0), 64'd1);
        if (exp_feat.size() != 0) check("feature_word", feature_in, exp_feat.pop_front());
        beats--;
      end else begin
        check("feature_idle_zero", feature_in, 64'd0);
      end
      if (cmp_valid) begin
        check("cmp_expected", 64'(exp_cmp.size() != 0), 64'd1);
        if (exp_cmp.size() != 0) begin
          o = exp_cmp.pop_front();
          check("cmp_op_order", 64'(cmp_op), 64'(o == OP_DEL));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_pos = '0;
    feat_valid = 1'b0; feat_data = '0; add_done = 1'b0; del_done = 1'b0;
    tick(); tick();
    check("rst_add", 64'(add_anchor), 64'd0);
    check("rst_del", 64'(del_anchor), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_cmp", 64'(cmp_valid), 64'd0);
    check("rst_level", 64'(cmd_level), 64'd0);
    check("rst_feature", feature_in, 64'd0);
    check("rst_pos", 64'(pos_encode), 64'd0);
    rst = 1'b0;
    tick();
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_feat_ready", 64'(feat_ready), 64'd1);

    // Delete command.
    push_cmd(OP_DEL, 18'o310230);
    check("t1_latency", 64'(del_anchor), 64'd0);
    tick();
    check("t1_del_pulse", 64'(del_anchor), 64'd1);
    check("t1_pos", 64'(pos_encode), 64'(18'o310230));
    check("t1_busy", 64'(busy), 64'd1);
    tick();
    check("t1_del_width", 64'(del_anchor), 64'd0);
    check("t1_pos_hold", 64'(pos_encode), 64'(18'o310230));
    repeat (4) tick();
    check("t1_no_early_cmp", 64'(cmp_valid), 64'd0);
    del_done = 1'b1; #1;
    check("t1_cmp_valid", 64'(cmp_valid), 64'd1);
    check("t1_cmp_op", 64'(cmp_op), 64'd1);
    tick(); del_done = 1'b0; #1;
    check("t1_busy_low", 64'(busy), 64'd0);
    check("t1_cmp_low", 64'(cmp_valid), 64'd0);

    // Add with features queued ahead of the command.
    for (int i = 1; i <= 9; i++) push_feat(64'(i));
    push_cmd(OP_ADD, 18'o123456);
    check("t2_level", 64'(cmd_level), 64'd1);
    wait_issue("t2_issue");
    check("t2_add_pulse", 64'(add_anchor), 64'd1);
    check("t2_word0", feature_in, 64'd1);
    for (int k = 2; k <= 9; k++) begin
      tick();
      check("t2_word", feature_in, 64'(k));
    end
    tick();
    check("t2_word_end_zero", feature_in, 64'd0);
    check("t2_busy_wait", 64'(busy), 64'd1);
    add_done = 1'b1; #1;
    check("t2_cmp_valid", 64'(cmp_valid), 64'd1);
    check("t2_cmp_op", 64'(cmp_op), 64'd0);
    tick(); add_done = 1'b0;

    // Head-of-line block: add short of features, delete behind it.
    for (int i = 1; i <= 5; i++) push_feat(64'h100 + 64'(i));
    push_cmd(OP_ADD, 18'o000111);
    push_cmd(OP_DEL, 18'o777000);
    for (int i = 0; i < 6; i++) begin
      check("t3_hol_block", 64'(add_anchor || del_anchor), 64'd0);
      tick();
    end
    check("t3_level", 64'(cmd_level), 64'd2);
    for (int i = 6; i <= 9; i++) push_feat(64'h100 + 64'(i));
    wait_issue("t3_issue_add");
    check("t3_add_first", 64'(add_anchor), 64'd1);
    repeat (9) tick();
    add_done = 1'b1; #1;
    check("t3_add_cmp", 64'(cmp_valid), 64'd1);
    tick(); add_done = 1'b0;
    check("t3_gap", 64'(del_anchor), 64'd0);
    wait_issue("t3_issue_del");
    check("t3_del_second", 64'(del_anchor), 64'd1);
    tick();
    del_done = 1'b1; #1;
    check("t3_del_cmp", 64'(cmp_valid), 64'd1);
    tick(); del_done = 1'b0;

    // Fill the command FIFO behind a blocked add.
    for (int i = 1; i <= 4; i++) push_cmd(OP_ADD, 18'(i));
    check("t4_level_full", 64'(cmd_level), 64'd4);
    check("t4_ready_low", 64'(cmd_ready), 64'd0);
    push_cmd(OP_DEL, 18'd5);
    check("t4_level_after_reject", 64'(cmd_level), 64'd4);
    for (int i = 1; i <= 9; i++) push_feat(64'h200 + 64'(i));
    wait_issue("t4_issue");
    check("t4_ready_back", 64'(cmd_ready), 64'd1);
    check("t4_level_3", 64'(cmd_level), 64'd3);
    repeat (9) tick();
    add_done = 1'b1; #1;
    check("t4_cmp", 64'(cmp_valid), 64'd1);
    tick(); add_done = 1'b0;

    // Done arriving mid-stream is latched until WAIT.
    for (int i = 1; i <= 9; i++) push_feat(64'h300 + 64'(i));
    wait_issue("t5_issue");
    repeat (4) tick();
    add_done = 1'b1; #1;
    check("t5_no_cmp_in_stream", 64'(cmp_valid), 64'd0);
    tick(); add_done = 1'b0;
    repeat (3) tick();
    check("t5_still_stream", 64'(cmp_valid), 64'd0);
    tick();
    check("t5_latched_done", 64'(cmp_valid), 64'd1);
    tick();
    check("t5_idle", 64'(busy), 64'd0);

    // Non-matching done is ignored.
    for (int i = 1; i <= 9; i++) push_feat(64'h400 + 64'(i));
    wait_issue("t6_issue");
    repeat (9) tick();
    del_done = 1'b1; #1;
    check("t6_wrong_done", 64'(cmp_valid), 64'd0);
    tick(); del_done = 1'b0;
    check("t6_still_busy", 64'(busy), 64'd1);
    add_done = 1'b1; #1;
    check("t6_right_done", 64'(cmp_valid), 64'd1);
    tick(); add_done = 1'b0;

    // Reset in the middle of a stream.
    for (int i = 1; i <= 9; i++) push_feat(64'h500 + 64'(i));
    wait_issue("t7_issue");
    push_cmd(OP_DEL, 18'o66);
    repeat (2) tick();
    rst = 1'b1; #1;
    check("t7_rst_add", 64'(add_anchor), 64'd0);
    check("t7_rst_feature", feature_in, 64'd0);
    check("t7_rst_busy", 64'(busy), 64'd0);
    check("t7_rst_cmp", 64'(cmp_valid), 64'd0);
    check("t7_rst_pos", 64'(pos_encode), 64'd0);
    check("t7_rst_level", 64'(cmd_level), 64'd0);
    flush_model();
    tick(); rst = 1'b0; tick();
    for (int i = 1; i <= 5; i++) push_feat(64'h600 + 64'(i));
    push_cmd(OP_ADD, 18'd7);
    for (int i = 0; i < 4; i++) begin
      check("t7_feat_flushed", 64'(add_anchor || del_anchor), 64'd0);
      tick();
    end
    rst = 1'b1; #1;
    flush_model();
    tick(); rst = 1'b0; tick();

`ifdef UPD_SCHED_TIMEOUT_EN
    // Watchdog drops a delete that never completes.
    push_cmd(OP_DEL, 18'o11);
    push_cmd(OP_DEL, 18'o22);
    wait_issue("t8_issue");
    repeat (14) tick();
    check("t8_no_early_timeout", 64'(cmp_valid), 64'd0);
    tick();
    check("t8_timeout_cmp", 64'(cmp_valid), 64'd1);
    check("t8_timeout_err", 64'(err_timeout), 64'd1);
    check("t8_timeout_op", 64'(cmp_op), 64'd1);
    tick();
    check("t8_idle", 64'(busy), 64'd0);
    wait_issue("t8_next_issue");
    check("t8_next_pos", 64'(pos_encode), 64'(18'o22));
    tick();
    del_done = 1'b1; #1;
    check("t8_normal_cmp", 64'(cmp_valid), 64'd1);
    check("t8_normal_err", 64'(err_timeout), 64'd0);
    tick(); del_done = 1'b0;
`endif

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
